sd_req_arbiter: RTL and testbench

- Arbitrates four sector-request channels onto the single SD-card sector interface: floppy drives A/B (channels 0,1) and ACSI targets 0/1 (channels 2,3).
- Replaces ad-hoc floppy/ACSI muxing at top level; sits directly between the atarist core's FDC/ACSI request outputs and the SD card controller.
- Latches one request at a time and routes the chosen LBA and write data to the card. Gates busy/strobe/done back to the granted channel only. Guards against a hung card with a timeout.

---
 rtl/sd_req_arbiter.sv | 151 +++++++++++++++
 tb/tb_sd_req_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_req_arbiter.sv
// Arbitrates floppy A/B (ch0/1) and ACSI 0/1 (ch2/3) sector requests onto one SD card port.
// One request is latched at a time; card handshakes are routed back to the granted channel only.
module sd_req_arbiter #(
    parameter int TIMEOUT_W = 24,
    parameter bit RR_EN     = 1'b1
) (
    input  logic        clk_32,
    input  logic        reset,
    input  logic [3:0]  req_rd,
    input  logic [3:0]  req_wr,
    input  logic [31:0] fdc_lba,
    input  logic [31:0] acsi_lba,
    input  logic [7:0]  fdc_din,
    input  logic [7:0]  acsi_din,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic [7:0]  sd_din,
    input  logic        sd_busy,
    input  logic        sd_done,
    input  logic        sd_dout_strobe,
    output logic [3:0]  ch_ack,
    output logic [3:0]  ch_strobe,
    output logic [3:0]  ch_done,
    output logic [3:0]  ch_timeout,
    output logic        is_acsi
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_WAIT
    } state_t;

    localparam logic [TIMEOUT_W-1:0] WDOG_LAST = ~TIMEOUT_W'(1);

    state_t               state;
    logic [1:0]           grant;
    logic [1:0]           rr_ptr;
    logic                 dir_wr;
    logic [TIMEOUT_W-1:0] wdog;

    logic [3:0] req_any;
    logic [3:0] grant_oh;
    logic [1:0] winner;
    logic [1:0] cand;
    logic       req_found;
    logic       grant_req;
    logic       wdog_expire;

    assign req_any     = req_rd | req_wr;
    assign grant_oh    = 4'b0001 << grant;
    assign grant_req   = dir_wr ? req_wr[grant] : req_rd[grant];
    // Fires one cycle early so the registered pulse lands after exactly 2^TIMEOUT_W-1 cycles.
    assign wdog_expire = (wdog == WDOG_LAST);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        winner    = 2'd0;
        req_found = 1'b0;
        cand      = 2'd0;
        for (int i = 0; i < 4; i++) begin
            cand = RR_EN ? rr_ptr + 2'(i) : 2'(i);
            if (!req_found && req_any[cand]) begin
                winner    = cand;
                req_found = 1'b1;
            end
        end
    end

    assign ch_ack    = (state == S_BUSY && sd_busy)        ? grant_oh : 4'b0000;
    assign ch_strobe = (state == S_BUSY && sd_dout_strobe) ? grant_oh : 4'b0000;
    assign sd_din    = is_acsi ? acsi_din : fdc_din;

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_32 or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            grant      <= 2'd0;
            rr_ptr     <= 2'd0;
            dir_wr     <= 1'b0;
            wdog       <= '0;
            sd_lba     <= 32'd0;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            is_acsi    <= 1'b0;
            ch_done    <= 4'b0000;
            ch_timeout <= 4'b0000;
        end else begin
            ch_done    <= 4'b0000;
            ch_timeout <= 4'b0000;
            case (state)
                S_IDLE: begin
                    if (req_found) begin
                        grant   <= winner;
                        is_acsi <= winner[1];
                        sd_lba  <= winner[1] ? acsi_lba : fdc_lba;
                        dir_wr  <= !req_rd[winner];
                        sd_rd   <= req_rd[winner];
                        sd_wr   <= !req_rd[winner];
                        wdog    <= '0;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wdog <= wdog + TIMEOUT_W'(1);
                    if (sd_done) begin
                        // Card finished without ever showing busy: complete in one step.
                        sd_rd   <= 1'b0;
                        sd_wr   <= 1'b0;
                        ch_done <= grant_oh;
                        rr_ptr  <= grant + 2'd1;
                        state   <= S_WAIT;
                    end else if (sd_busy) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        state <= S_BUSY;
                    end else if (!grant_req) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        state <= S_IDLE;
                    end else if (wdog_expire) begin
                        sd_rd      <= 1'b0;
                        sd_wr      <= 1'b0;
                        ch_timeout <= grant_oh;
                        state      <= S_WAIT;
                    end
                end
                S_BUSY: begin
                    wdog <= wdog + TIMEOUT_W'(1);
                    if (sd_done) begin
                        ch_done <= grant_oh;
                        rr_ptr  <= grant + 2'd1;
                        state   <= S_WAIT;
                    end else if (wdog_expire) begin
                        ch_timeout <= grant_oh;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!sd_busy && !grant_req) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Scoreboard bench for sd_req_arbiter: instance 0 is round-robin with a long watchdog,
// instance 1 is fixed-priority with TIMEOUT_W=8.
module tb_sd_req_arbiter;

    typedef struct {
        int          ch;
        bit          wr;
        logic [31:0] lba;
        logic [7:0]  din;
    } exp_t;

    logic        clk_32 = 1'b0;
    logic        reset;
    logic [3:0]  req_rd [2];
    logic [3:0]  req_wr [2];
    logic [31:0] fdc_lba, acsi_lba;
    logic [7:0]  fdc_din, acsi_din;
    logic        sd_busy [2];
    logic        sd_done [2];
    logic        sd_strobe [2];
    logic [31:0] sd_lba [2];
    logic        sd_rd [2];
    logic        sd_wr [2];
    logic [7:0]  sd_din [2];
    logic [3:0]  ch_ack [2];
    logic [3:0]  ch_strobe [2];
    logic [3:0]  ch_done [2];
    logic [3:0]  ch_timeout [2];
    logic        is_acsi [2];

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk_32 = ~clk_32;

    sd_req_arbiter #(.TIMEOUT_W(24), .RR_EN(1'b1)) u_rr (
        .clk_32(clk_32), .reset(reset), .req_rd(req_rd[0]), .req_wr(req_wr[0]),
        .fdc_lba(fdc_lba), .acsi_lba(acsi_lba), .fdc_din(fdc_din), .acsi_din(acsi_din),
        .sd_lba(sd_lba[0]), .sd_rd(sd_rd[0]), .sd_wr(sd_wr[0]), .sd_din(sd_din[0]),
        .sd_busy(sd_busy[0]), .sd_done(sd_done[0]), .sd_dout_strobe(sd_strobe[0]),
        .ch_ack(ch_ack[0]), .ch_strobe(ch_strobe[0]), .ch_done(ch_done[0]),
        .ch_timeout(ch_timeout[0]), .is_acsi(is_acsi[0])
    );

    sd_req_arbiter #(.TIMEOUT_W(8), .RR_EN(1'b0)) u_fix (
        .clk_32(clk_32), .reset(reset), .req_rd(req_rd[1]), .req_wr(req_wr[1]),
        .fdc_lba(fdc_lba), .acsi_lba(acsi_lba), .fdc_din(fdc_din), .acsi_din(acsi_din),
        .sd_lba(sd_lba[1]), .sd_rd(sd_rd[1]), .sd_wr(sd_wr[1]), .sd_din(sd_din[1]),
        .sd_busy(sd_busy[1]), .sd_done(sd_done[1]), .sd_dout_strobe(sd_strobe[1]),
        .ch_ack(ch_ack[1]), .ch_strobe(ch_strobe[1]), .ch_done(ch_done[1]),
        .ch_timeout(ch_timeout[1]), .is_acsi(is_acsi[1])
    );

    task automatic tick();
        @(posedge clk_32);
        #1;
    endtask

    task automatic expect_grant(input int ch, input bit wr);
        exp_t e;
        e.ch  = ch;
        e.wr  = wr;
        e.lba = (ch < 2) ? fdc_lba : acsi_lba;
        e.din = (ch < 2) ? fdc_din : acsi_din;
        exp_q.push_back(e);
    endtask

    // Waits for the card request, pops the scoreboard and checks the latched grant.
    task automatic wait_grant(input int u, output exp_t e);
        int lat;
        lat = 0;
        while (!(sd_rd[u] || sd_wr[u]) && lat < 16) begin
            tick();
            lat++;
        end
        n_vec++;
        if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL grant_queue u%0d: request seen, scoreboard empty", u);
            e.ch = 0; e.wr = 1'b0; e.lba = 32'd0; e.din = 8'd0;
            return;
        end
        e = exp_q.pop_front();
        n_vec++;
        if (lat !== 1) begin
            n_miss++;
            $display("FAIL grant_latency u%0d ch%0d: got %0d cycles, expected 1", u, e.ch, lat);
        end
        n_vec++;
        if (sd_lba[u] !== e.lba) begin
            n_miss++;
            $display("FAIL grant_lba u%0d ch%0d: got %h, expected %h", u, e.ch, sd_lba[u], e.lba);
        end
        n_vec++;
        if ({sd_rd[u], sd_wr[u]} !== {~e.wr, e.wr}) begin
            n_miss++;
            $display("FAIL grant_dir u%0d ch%0d: rd/wr got %b%b, expected %b%b", u, e.ch,
                     sd_rd[u], sd_wr[u], ~e.wr, e.wr);
        end
        n_vec++;
        if (is_acsi[u] !== (e.ch >= 2)) begin
            n_miss++;
            $display("FAIL grant_is_acsi u%0d ch%0d: got %b, expected %b", u, e.ch, is_acsi[u], e.ch >= 2);
        end
    endtask

    // Card side: busy, strobes, done; requester drops its bit and optionally re-requests.
    task automatic finish_xfer(input int u, input exp_t e, input int nstrobe, input bit rearm);
        logic [3:0] oh;
        int good;
        oh = 4'b0001 << e.ch;
        tick();
        tick();
        n_vec++;
        if ((e.wr ? sd_wr[u] : sd_rd[u]) !== 1'b1) begin
            n_miss++;
            $display("FAIL issue_hold u%0d ch%0d: request to card dropped before busy", u, e.ch);
        end
        sd_busy[u] = 1'b1;
        tick();
        n_vec++;
        if ({sd_rd[u], sd_wr[u]} !== 2'b00) begin
            n_miss++;
            $display("FAIL issue_drop u%0d ch%0d: rd/wr got %b%b, expected 00", u, e.ch, sd_rd[u], sd_wr[u]);
        end
        n_vec++;
        if (ch_ack[u] !== oh) begin
            n_miss++;
            $display("FAIL ack_route u%0d: got %b, expected %b", u, ch_ack[u], oh);
        end
        if (e.wr) begin
            n_vec++;
            if (sd_din[u] !== e.din) begin
                n_miss++;
                $display("FAIL din_mux u%0d ch%0d: got %h, expected %h", u, e.ch, sd_din[u], e.din);
            end
        end
        good = 0;
        for (int i = 0; i < nstrobe; i++) begin
            sd_strobe[u] = 1'b1;
            #1;
            if (ch_strobe[u] === oh) good++;
            tick();
        end
        sd_strobe[u] = 1'b0;
        #1;
        n_vec++;
        if (good !== nstrobe || ch_strobe[u] !== 4'b0000) begin
            n_miss++;
            $display("FAIL strobe_route u%0d ch%0d: %0d routed strobes, expected %0d (idle %b)",
                     u, e.ch, good, nstrobe, ch_strobe[u]);
        end
        n_vec++;
        if (sd_lba[u] !== e.lba) begin
            n_miss++;
            $display("FAIL lba_stable u%0d ch%0d: got %h, expected %h", u, e.ch, sd_lba[u], e.lba);
        end
        sd_done[u] = 1'b1;
        tick();
        sd_done[u] = 1'b0;
        n_vec++;
        if (ch_done[u] !== oh) begin
            n_miss++;
            $display("FAIL done_pulse u%0d: got %b, expected %b", u, ch_done[u], oh);
        end
        if (e.wr) req_wr[u][e.ch] = 1'b0;
        else      req_rd[u][e.ch] = 1'b0;
        sd_busy[u] = 1'b0;
        tick();
        n_vec++;
        if (ch_done[u] !== 4'b0000) begin
            n_miss++;
            $display("FAIL done_width u%0d: got %b, expected 0000", u, ch_done[u]);
        end
        if (rearm) begin
            if (e.wr) req_wr[u][e.ch] = 1'b1;
            else      req_rd[u][e.ch] = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk_32);
        #1;
        for (int u = 0; u < 2; u++) begin
            n_vec++;
            if ({sd_lba[u], sd_rd[u], sd_wr[u], ch_ack[u], ch_strobe[u], ch_done[u],
                 ch_timeout[u], is_acsi[u]} !== 52'd0) begin
                n_miss++;
                $display("FAIL reset_outputs u%0d: lba=%h rd=%b wr=%b acsi=%b", u, sd_lba[u],
                         sd_rd[u], sd_wr[u], is_acsi[u]);
            end
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        exp_t e;
        fdc_lba  = 32'h0000_0400;
        acsi_lba = 32'h0002_0000;
        req_rd[0] = 4'b1111;
        expect_grant(0, 1'b0); expect_grant(1, 1'b0); expect_grant(2, 1'b0);
        expect_grant(3, 1'b0); expect_grant(0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            wait_grant(0, e);
            if (k == 4) req_rd[0] = req_rd[0] & 4'b0001;
            finish_xfer(0, e, 2, k < 4);
        end
    endtask

    task automatic test_single_read();
        exp_t e;
        fdc_lba = 32'h0000_0123;
        req_rd[0][0] = 1'b1;
        #1;
        n_vec++;
        if (sd_rd[0] !== 1'b0) begin
            n_miss++;
            $display("FAIL read_early u0: sd_rd got %b before clock, expected 0", sd_rd[0]);
        end
        expect_grant(0, 1'b0);
        wait_grant(0, e);
        fdc_lba = 32'hDEAD_BEEF;
        finish_xfer(0, e, 512, 1'b0);
    endtask

    task automatic test_write_acsi();
        exp_t e;
        acsi_lba = 32'h0001_0000;
        acsi_din = 8'hA5;
        req_wr[0][2] = 1'b1;
        expect_grant(2, 1'b1);
        wait_grant(0, e);
        finish_xfer(0, e, 0, 1'b0);
    endtask

    task automatic test_rd_wr_both();
        exp_t e;
        fdc_lba = 32'h0000_7777;
        fdc_din = 8'h3C;
        req_rd[0][0] = 1'b1;
        req_wr[0][0] = 1'b1;
        expect_grant(0, 1'b0);
        expect_grant(0, 1'b1);
        wait_grant(0, e);
        finish_xfer(0, e, 3, 1'b0);
        wait_grant(0, e);
        finish_xfer(0, e, 0, 1'b0);
    endtask

    task automatic test_abort();
        exp_t e;
        fdc_lba = 32'h0000_0A0A;
        req_rd[0][1] = 1'b1;
        expect_grant(1, 1'b0);
        wait_grant(0, e);
        tick();
        req_rd[0][1] = 1'b0;
        tick();
        n_vec++;
        if (sd_rd[0] !== 1'b0) begin
            n_miss++;
            $display("FAIL abort_drop u0: sd_rd got %b, expected 0", sd_rd[0]);
        end
        tick();
        n_vec++;
        if (ch_done[0] !== 4'b0000 || ch_ack[0] !== 4'b0000) begin
            n_miss++;
            $display("FAIL abort_quiet u0: done=%b ack=%b, expected 0000", ch_done[0], ch_ack[0]);
        end
        req_rd[0][0] = 1'b1;
        expect_grant(0, 1'b0);
        wait_grant(0, e);
        finish_xfer(0, e, 1, 1'b0);
    endtask

    task automatic test_fixed_priority();
        exp_t e;
        fdc_lba = 32'h0000_0B00;
        req_rd[1] = 4'b1111;
        for (int k = 0; k < 3; k++) expect_grant(0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            wait_grant(1, e);
            if (k == 2) req_rd[1] = req_rd[1] & 4'b0001;
            finish_xfer(1, e, 2, k < 2);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        int early;
        fdc_lba = 32'h0000_0055;
        req_rd[1][1] = 1'b1;
        expect_grant(1, 1'b0);
        wait_grant(1, e);
        early = 0;
        for (int i = 1; i < 255; i++) begin
            tick();
            if (ch_timeout[1] !== 4'b0000 || sd_rd[1] !== 1'b1) early++;
        end
        n_vec++;
        if (early !== 0) begin
            n_miss++;
            $display("FAIL timeout_early u1: %0d cycles with early timeout/drop, expected 0", early);
        end
        tick();
        n_vec++;
        if (ch_timeout[1] !== 4'b0010 || sd_rd[1] !== 1'b0) begin
            n_miss++;
            $display("FAIL timeout_pulse u1: timeout=%b rd=%b, expected 0010/0", ch_timeout[1], sd_rd[1]);
        end
        tick();
        n_vec++;
        if (ch_timeout[1] !== 4'b0000) begin
            n_miss++;
            $display("FAIL timeout_width u1: got %b, expected 0000", ch_timeout[1]);
        end
        req_rd[1][1] = 1'b0;
        tick();
        acsi_lba = 32'h0003_1000;
        acsi_din = 8'h5A;
        req_wr[1][2] = 1'b1;
        expect_grant(2, 1'b1);
        wait_grant(1, e);
        finish_xfer(1, e, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        fdc_lba = 32'h0000_0C0C;
        req_rd[0][1] = 1'b1;
        expect_grant(1, 1'b0);
        wait_grant(0, e);
        sd_busy[0] = 1'b1;
        tick();
        n_vec++;
        if (ch_ack[0] !== 4'b0010) begin
            n_miss++;
            $display("FAIL mid_busy u0: ack got %b, expected 0010", ch_ack[0]);
        end
        reset = 1'b1;
        req_rd[0] = 4'b0000;
        sd_busy[0] = 1'b0;
        tick();
        n_vec++;
        if ({sd_lba[0], sd_rd[0], sd_wr[0], ch_ack[0], ch_strobe[0], ch_done[0],
             ch_timeout[0], is_acsi[0]} !== 52'd0) begin
            n_miss++;
            $display("FAIL mid_reset u0: lba=%h rd=%b wr=%b ack=%b", sd_lba[0], sd_rd[0], sd_wr[0], ch_ack[0]);
        end
        reset = 1'b0;
        tick();
        acsi_lba = 32'h0BAD_F00D;
        fdc_lba  = 32'h0000_0001;
        req_rd[0][3] = 1'b1;
        expect_grant(3, 1'b0);
        wait_grant(0, e);
        finish_xfer(0, e, 4, 1'b0);
    endtask

    initial begin
        reset    = 1'b1;
        fdc_lba  = 32'd0;
        acsi_lba = 32'd0;
        fdc_din  = 8'h11;
        acsi_din = 8'h22;
        for (int u = 0; u < 2; u++) begin
            req_rd[u]    = 4'b0000;
            req_wr[u]    = 4'b0000;
            sd_busy[u]   = 1'b0;
            sd_done[u]   = 1'b0;
            sd_strobe[u] = 1'b0;
        end
        test_reset();
        test_round_robin();
        test_single_read();
        test_write_acsi();
        test_rd_wr_both();
        test_abort();
        test_fixed_priority();
        test_timeout();
        test_reset_mid();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: %0d grants never seen, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_time_limit: simulation still running, expected completion");
        $fatal(1, "time limit");
    end

endmodule
